// File: rtl/tl_source_flight_monitor_pkg.sv
// Shared types for the TileLink source-ID flight monitor.
package tl_mon_pkg;

    localparam int OVF_W = 8;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_DUP_A     = 2'd1,
        ERR_D_UNKNOWN = 2'd2,
        ERR_TIMEOUT   = 2'd3
    } err_code_e;

endpackage

// File: rtl/tl_source_flight_monitor_if.sv
// A/D channel signals observed by the flight monitor.
interface tl_mon_if #(
    parameter int SOURCE_BITS = 4
);
    logic                   a_valid;
    logic                   a_ready;
    logic                   a_first;
    logic [SOURCE_BITS-1:0] a_source;
    logic                   d_valid;
    logic                   d_ready;
    logic                   d_last;
    logic [SOURCE_BITS-1:0] d_source;

    modport master (
        output a_valid, a_ready, a_first, a_source,
        output d_valid, d_ready, d_last, d_source
    );

    modport slave (
        input a_valid, a_ready, a_first, a_source,
        input d_valid, d_ready, d_last, d_source
    );
endinterface

// File: rtl/tl_source_flight_monitor_watchdog.sv
// Forward-progress counter: pulses once every TIMEOUT stalled cycles.
module tl_mon_watchdog #(
    parameter int TIMEOUT = 4096
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clr_i,
    output logic timeout_o
);
    localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d     = cnt_q;
        timeout_o = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d     = '0;
            timeout_o = 1'b1;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
endmodule

// File: rtl/tl_source_flight_monitor.sv
// Tracks in-flight TileLink source IDs and latches the first protocol error.
module tl_source_flight_monitor
    import tl_mon_pkg::*;
#(
    parameter int SOURCE_BITS  = 4,
    parameter int TIMEOUT      = 4096,
    parameter bit FATAL_ON_ERR = 1'b0
) (
    input  logic                   clock,
    input  logic                   reset_n,
    tl_mon_if.slave                tl,
    input  logic                   err_clr,
    output logic                   err_valid,
    output logic [1:0]             err_code,
    output logic [SOURCE_BITS-1:0] err_source,
    output logic [OVF_W-1:0]       err_overflow,
    output logic [SOURCE_BITS:0]   inflight_cnt,
    output logic                   idle
);
    localparam int N  = 1 << SOURCE_BITS;
    localparam int CW = SOURCE_BITS + 1;

    logic [N-1:0]             bitmap_q, bitmap_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     idle_q;
    logic                     err_valid_q, err_valid_d;
    err_code_e                err_code_q, err_code_d;
    logic [SOURCE_BITS-1:0]   err_src_q, err_src_d;
    logic [OVF_W-1:0]         ovf_q, ovf_d, ovf_base;

    logic afire, dfire, d_hit, a_hit;
    logic dup, dunk, retire, alloc, tmo;
    logic [N-1:0] retire_mask, alloc_mask;
    logic [SOURCE_BITS-1:0] low_src;

    assign afire = tl.a_valid & tl.a_ready;
    assign dfire = tl.d_valid & tl.d_ready;
    assign d_hit = bitmap_q[tl.d_source];
    assign a_hit = bitmap_q[tl.a_source];

    // Checks see the bitmap from before this cycle's update.
    assign dunk   = dfire & ~d_hit;
    assign retire = dfire & tl.d_last & d_hit;
    assign dup    = afire & tl.a_first & a_hit
                  & ~(retire & (tl.d_source == tl.a_source));
    assign alloc  = afire & tl.a_first & ~dup;

    assign retire_mask = retire ? (N'(1) << tl.d_source) : '0;
    assign alloc_mask  = alloc  ? (N'(1) << tl.a_source) : '0;
    assign bitmap_d    = (bitmap_q & ~retire_mask) | alloc_mask;
    assign cnt_d       = cnt_q + CW'(alloc) - CW'(retire);

    always_comb begin
        low_src = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (bitmap_q[i]) low_src = SOURCE_BITS'(i);
        end
    end

    tl_mon_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clock     (clock),
        .reset_n   (reset_n),
        .clr_i     ((cnt_q == '0) | dfire),
        .timeout_o (tmo)
    );

    logic [1:0]             n_err;
    logic                   held, capture, lost;
    err_code_e              ev_code;
    logic [SOURCE_BITS-1:0] ev_src;

    always_comb begin
        ev_code = ERR_NONE;
        ev_src  = '0;
        if (dup) begin
            ev_code = ERR_DUP_A;
            ev_src  = tl.a_source;
        end else if (dunk) begin
            ev_code = ERR_D_UNKNOWN;
            ev_src  = tl.d_source;
        end else if (tmo) begin
            ev_code = ERR_TIMEOUT;
            ev_src  = low_src;
        end
    end

    always_comb begin
        n_err       = 2'(dup) + 2'(dunk) + 2'(tmo);
        held        = err_valid_q & ~err_clr;
        capture     = ~held & (n_err != 2'd0);
        lost        = capture ? (n_err > 2'd1) : (n_err != 2'd0);
        err_valid_d = held;
        err_code_d  = err_clr ? ERR_NONE : err_code_q;
        err_src_d   = err_clr ? '0 : err_src_q;
        ovf_base    = err_clr ? '0 : ovf_q;
        if (capture) begin
            err_valid_d = 1'b1;
            err_code_d  = ev_code;
            err_src_d   = ev_src;
        end
        ovf_d = ovf_base;
        if (lost && ovf_base != '1) ovf_d = ovf_base + 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bitmap_q    <= '0;
            cnt_q       <= '0;
            idle_q      <= 1'b1;
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            err_src_q   <= '0;
            ovf_q       <= '0;
        end else begin
            bitmap_q    <= bitmap_d;
            cnt_q       <= cnt_d;
            idle_q      <= (cnt_d == '0);
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
            err_src_q   <= err_src_d;
            ovf_q       <= ovf_d;
        end
    end

    assign err_valid    = err_valid_q;
    assign err_code     = err_code_q;
    assign err_source   = err_src_q;
    assign err_overflow = ovf_q;
    assign inflight_cnt = cnt_q;
    assign idle         = idle_q;

`ifndef SYNTHESIS
    always @(posedge clock) begin
        if (FATAL_ON_ERR && reset_n && capture)
            $fatal(1, "tl_source_flight_monitor: error code %0d src %0d",
                   ev_code, ev_src);
    end
`endif
endmodule

// File: tb/tb_tl_source_flight_monitor.sv
// Randomized and directed bench for tl_source_flight_monitor.
module tb_tl_source_flight_monitor;
    localparam int SB = 4;
    localparam int N  = 1 << SB;
    localparam int TO = 8;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic err_clr = 1'b0;
    logic err_valid, idle;
    logic [1:0] err_code;
    logic [SB-1:0] err_source;
    logic [7:0] err_overflow;
    logic [SB:0] inflight_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    bit m_bm [N];
    int m_cnt, m_stall, m_code, m_src, m_ovf;
    bit m_valid;

    tl_mon_if #(.SOURCE_BITS(SB)) bus ();

    tl_source_flight_monitor #(
        .SOURCE_BITS (SB),
        .TIMEOUT     (TO),
        .FATAL_ON_ERR(1'b0)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .tl           (bus.slave),
        .err_clr      (err_clr),
        .err_valid    (err_valid),
        .err_code     (err_code),
        .err_source   (err_source),
        .err_overflow (err_overflow),
        .inflight_cnt (inflight_cnt),
        .idle         (idle)
    );

    always #5 clock = ~clock;

    task automatic clear_in();
        bus.a_valid = 0; bus.a_ready = 0; bus.a_first = 0; bus.a_source = '0;
        bus.d_valid = 0; bus.d_ready = 0; bus.d_last = 0; bus.d_source = '0;
        err_clr = 0;
    endtask

    task automatic drive_a(input int src);
        bus.a_valid = 1; bus.a_ready = 1; bus.a_first = 1; bus.a_source = SB'(src);
    endtask

    task automatic drive_d(input int src, input bit last);
        bus.d_valid = 1; bus.d_ready = 1; bus.d_last = last; bus.d_source = SB'(src);
    endtask

    task automatic model_reset();
        foreach (m_bm[i]) m_bm[i] = 0;
        m_cnt = 0; m_stall = 0; m_code = 0; m_src = 0; m_ovf = 0; m_valid = 0;
    endtask

    task automatic model_step();
        bit af, df, dunk, ret, dup, alloc, tmo;
        int as, ds, low, extra;
        int codes[$];
        int srcs[$];
        af = bus.a_valid && bus.a_ready;
        df = bus.d_valid && bus.d_ready;
        as = int'(bus.a_source);
        ds = int'(bus.d_source);
        dunk  = df && !m_bm[ds];
        ret   = df && bus.d_last && m_bm[ds];
        dup   = af && bus.a_first && m_bm[as] && !(ret && ds == as);
        alloc = af && bus.a_first && !dup;
        low = 0;
        for (int i = 0; i < N; i++) if (m_bm[i]) begin low = i; break; end
        tmo = 0;
        if (m_cnt == 0 || df) m_stall = 0;
        else begin
            m_stall++;
            if (m_stall == TO) begin tmo = 1; m_stall = 0; end
        end
        if (dup)  begin codes.push_back(1); srcs.push_back(as); end
        if (dunk) begin codes.push_back(2); srcs.push_back(ds); end
        if (tmo)  begin codes.push_back(3); srcs.push_back(low); end
        if (err_clr) begin m_valid = 0; m_code = 0; m_src = 0; m_ovf = 0; end
        extra = 0;
        if (codes.size() > 0) begin
            if (!m_valid) begin
                m_valid = 1; m_code = codes[0]; m_src = srcs[0];
                extra = codes.size() - 1;
            end else extra = codes.size();
        end
        if (extra > 0 && m_ovf < 255) m_ovf++;
        if (ret) m_bm[ds] = 0;
        if (alloc) m_bm[as] = 1;
        m_cnt = 0;
        foreach (m_bm[i]) m_cnt += int'(m_bm[i]);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        clear_in();
        reset_n = 0;
        model_reset();
        repeat (2) @(posedge clock);
        #1 reset_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (err_code !== 2'd0 || err_source !== '0 || err_overflow !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_capture: code=%0d src=%0d ovf=%0d required 0/0/0",
                     err_code, err_source, err_overflow);
        end
        for (int i = 0; i < 100; i++) begin
            cycle();
            tests_run++;
            if (idle !== 1'b1 || inflight_cnt !== '0 || err_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_idle[%0d]: idle=%b cnt=%0d ev=%b required 1/0/0",
                         i, idle, inflight_cnt, err_valid);
            end
        end
    endtask

    task automatic test_legal_flow();
        do_reset();
        drive_a(3); cycle(); clear_in();
        tests_run++;
        if (inflight_cnt !== 5'd1 || idle !== 1'b0) begin
            tests_failed++;
            $display("FAIL legal_alloc: cnt=%0d idle=%b required 1/0", inflight_cnt, idle);
        end
        drive_d(3, 1); cycle(); clear_in();
        tests_run++;
        if (inflight_cnt !== 5'd0 || idle !== 1'b1 || err_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL legal_retire: cnt=%0d idle=%b ev=%b required 0/1/0",
                     inflight_cnt, idle, err_valid);
        end
    endtask

    task automatic test_duplicate();
        do_reset();
        drive_a(5); cycle();
        drive_a(5); cycle(); clear_in();
        tests_run++;
        if (err_valid !== 1'b1 || err_code !== 2'd1 || err_source !== 4'd5
            || inflight_cnt !== 5'd1) begin
            tests_failed++;
            $display("FAIL dup_a: ev=%b code=%0d src=%0d cnt=%0d required 1/1/5/1",
                     err_valid, err_code, err_source, inflight_cnt);
        end
    endtask

    task automatic test_unknown_d();
        do_reset();
        drive_d(9, 1); cycle(); clear_in();
        tests_run++;
        if (err_valid !== 1'b1 || err_code !== 2'd2 || err_source !== 4'd9) begin
            tests_failed++;
            $display("FAIL d_unknown: ev=%b code=%0d src=%0d required 1/2/9",
                     err_valid, err_code, err_source);
        end
        drive_d(9, 1); cycle(); clear_in();
        tests_run++;
        if (err_overflow !== 8'd1 || err_code !== 2'd2) begin
            tests_failed++;
            $display("FAIL d_unknown_ovf: ovf=%0d code=%0d required 1/2",
                     err_overflow, err_code);
        end
        err_clr = 1; cycle(); clear_in();
        tests_run++;
        if (err_valid !== 1'b0 || err_code !== 2'd0 || err_source !== '0
            || err_overflow !== 8'd0) begin
            tests_failed++;
            $display("FAIL err_clr: ev=%b code=%0d src=%0d ovf=%0d required 0/0/0/0",
                     err_valid, err_code, err_source, err_overflow);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        drive_a(2); cycle();
        drive_a(2); drive_d(2, 1); cycle(); clear_in();
        tests_run++;
        if (err_valid !== 1'b0 || inflight_cnt !== 5'd1) begin
            tests_failed++;
            $display("FAIL retire_realloc: ev=%b cnt=%0d required 0/1",
                     err_valid, inflight_cnt);
        end
        do_reset();
        drive_a(4); drive_d(4, 1); cycle(); clear_in();
        tests_run++;
        if (err_code !== 2'd2 || err_source !== 4'd4 || inflight_cnt !== 5'd1) begin
            tests_failed++;
            $display("FAIL fresh_a_d: code=%0d src=%0d cnt=%0d required 2/4/1",
                     err_code, err_source, inflight_cnt);
        end
        // clear plus two new errors: top one captured, the other is lost
        err_clr = 1; drive_a(4); drive_d(7, 0); cycle(); clear_in();
        tests_run++;
        if (err_valid !== 1'b1 || err_code !== 2'd1 || err_source !== 4'd4
            || err_overflow !== 8'd1) begin
            tests_failed++;
            $display("FAIL clr_and_err: ev=%b code=%0d src=%0d ovf=%0d required 1/1/4/1",
                     err_valid, err_code, err_source, err_overflow);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        drive_a(6); cycle();
        drive_a(1); cycle(); clear_in();
        drive_d(6, 0); cycle(); clear_in();
        repeat (5) cycle();
        drive_d(6, 0); cycle(); clear_in();
        repeat (7) cycle();
        tests_run++;
        if (err_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL tmo_early: ev=%b required 0", err_valid);
        end
        cycle();
        tests_run++;
        if (err_valid !== 1'b1 || err_code !== 2'd3 || err_source !== 4'd1) begin
            tests_failed++;
            $display("FAIL tmo_fire: ev=%b code=%0d src=%0d required 1/3/1",
                     err_valid, err_code, err_source);
        end
        repeat (7) cycle();
        tests_run++;
        if (err_overflow !== 8'd0) begin
            tests_failed++;
            $display("FAIL tmo_ovf_early: ovf=%0d required 0", err_overflow);
        end
        cycle();
        tests_run++;
        if (err_overflow !== 8'd1 || inflight_cnt !== 5'd2) begin
            tests_failed++;
            $display("FAIL tmo_refire: ovf=%0d cnt=%0d required 1/2",
                     err_overflow, inflight_cnt);
        end
        repeat (3) cycle();
        #2 reset_n = 0;
        #1;
        tests_run++;
        if (err_valid !== 1'b0 || err_code !== 2'd0 || err_source !== '0
            || err_overflow !== 8'd0 || inflight_cnt !== '0 || idle !== 1'b1) begin
            tests_failed++;
            $display("FAIL async_reset: ev=%b code=%0d src=%0d ovf=%0d cnt=%0d idle=%b required 0/0/0/0/0/1",
                     err_valid, err_code, err_source, err_overflow, inflight_cnt, idle);
        end
        do_reset();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            clear_in();
            if ((i % 60) < 48) begin
                bus.a_valid  = $urandom_range(0, 1) == 1;
                bus.a_ready  = $urandom_range(0, 3) != 0;
                bus.a_first  = $urandom_range(0, 3) != 0;
                bus.a_source = SB'($urandom_range(0, 4));
                bus.d_valid  = $urandom_range(0, 1) == 1;
                bus.d_ready  = $urandom_range(0, 3) != 0;
                bus.d_last   = $urandom_range(0, 2) != 0;
                bus.d_source = SB'($urandom_range(0, 4));
                err_clr      = $urandom_range(0, 9) == 0;
            end
            cycle();
            tests_run++;
            if (err_valid !== m_valid || int'(err_code) != m_code
                || int'(err_source) != m_src || int'(err_overflow) != m_ovf
                || int'(inflight_cnt) != m_cnt || idle !== (m_cnt == 0)) begin
                tests_failed++;
                $display("FAIL random[%0d]: ev=%b code=%0d src=%0d ovf=%0d cnt=%0d idle=%b required %b/%0d/%0d/%0d/%0d/%b",
                         i, err_valid, err_code, err_source, err_overflow,
                         inflight_cnt, idle, m_valid, m_code, m_src, m_ovf,
                         m_cnt, m_cnt == 0);
            end
        end
        clear_in();
    endtask

    initial begin
        clear_in();
        test_reset();
        test_legal_flow();
        test_duplicate();
        test_unknown_d();
        test_same_cycle();
        test_timeout();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/tl_source_flight_monitor.md
Name: tl_source_flight_monitor

Overview:
- Synthesizable TileLink-style A/D source-ID flight tracker.
- Sits beside a TL port and is the generating end of the protocol-check condition that the simulation-only assert checkers consume.
- Records which source IDs are in flight. Flags a duplicate A issue, a D response for an unknown source, and a forward-progress stall.
- Latches the first error in a sticky capture register that software or the bench can read and clear.

Parameters:
- SOURCE_BITS, 4: width of the source ID. Tracker holds 2^SOURCE_BITS entries, one outstanding request per source.
- TIMEOUT, 4096: number of consecutive stalled cycles that raises a timeout. Legal range 2..65535.
- FATAL_ON_ERR, 0: if 1, a simulation build (`ifndef SYNTHESIS) calls $fatal on any captured error.

Ports:
- clock  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- a_valid  in  1  A channel valid.
- a_ready  in  1  A channel ready.
- a_first  in  1  current A beat is the first beat of its message.
- a_source  in  SOURCE_BITS  A source ID.
- d_valid  in  1  D channel valid.
- d_ready  in  1  D channel ready.
- d_last  in  1  current D beat is the last beat of its message.
- d_source  in  SOURCE_BITS  D source ID.
- err_clr  in  1  single-cycle pulse that clears the capture register.
- err_valid  out  1  sticky error flag.
- err_code  out  2  error code: 0 none, 1 DUP_A, 2 D_UNKNOWN, 3 TIMEOUT.
- err_source  out  SOURCE_BITS  source ID of the captured error.
- err_overflow  out  8  saturating count of cycles in which an error was lost.
- inflight_cnt  out  SOURCE_BITS+1  number of sources in flight.
- idle  out  1  asserted when inflight_cnt == 0.

Behaviour:
- Reset: all registered state clears asynchronously. Outputs after reset: err_valid=0, err_code=0, err_source=0, err_overflow=0, inflight_cnt=0, idle=1. Tracker bitmap and watchdog counter are 0.
- Fire definitions: afire = a_valid & a_ready. dfire = d_valid & d_ready. Checks and updates run only on fire.
- All outputs are registered. An event at edge N is visible after edge N.
- D check: on every dfire beat, error D_UNKNOWN if bitmap[d_source]==0. The bitmap is sampled before this cycle's A update, so an A and a D for the same new source in the same cycle still gives D_UNKNOWN.
- Retire: dfire & d_last & bitmap[d_source] clears that bit.
- A check: on afire & a_first, error DUP_A if bitmap[a_source]==1 and the source is not retired in the same cycle.
- Allocate: otherwise afire & a_first sets the bit. Retire plus allocate of the same source in one cycle is legal; the bit stays set.
- Bitmap update: bitmap_next = (bitmap & ~retire_mask) | alloc_mask.
- inflight_cnt: +1 on allocate, -1 on retire; both in one cycle means no change. Illegal events never change the bitmap or the count.
- Watchdog (sub-module):
  - Counter cnt clears when inflight_cnt==0 or on any dfire.
  - Otherwise it increments each cycle.
  - When cnt reaches TIMEOUT-1 and increments, raise TIMEOUT and wrap cnt to 0. A persistent stall therefore re-raises every TIMEOUT cycles.
  - err_source for TIMEOUT is the lowest-index set bit of the bitmap.
- Capture priority within one cycle: DUP_A > D_UNKNOWN > TIMEOUT.
- Capture rules:
  - If err_valid==0 (after this cycle's clear), capture the highest-priority error.
  - Any additional error in the same cycle, or any error while err_valid==1, increments err_overflow by 1 per cycle, saturating at 255.
- err_clr:
  - Clears err_valid, err_code, err_source and err_overflow.
  - err_clr and a new error in the same cycle: the new error is captured and overflow ends at 0, or at 1 if that cycle also had a lower-priority error.
- Capture and the tracker are independent. Tracking continues unaffected while err_valid==1.

Decomposition:
- Package tl_mon_pkg: err_code_e enum (ERR_NONE, ERR_DUP_A, ERR_D_UNKNOWN, ERR_TIMEOUT) and OVF_W=8.
- Sub-module tl_mon_watchdog: TIMEOUT counter with clear, increment and wrap, plus the timeout pulse output.
- Lowest-set-bit priority encoder stays inline.

Test Plan:
- Reset then idle: no stimulus → idle=1, inflight_cnt=0, err_valid=0 held for 100 cycles.
- Legal flow: A fires src 3 (a_first) → inflight_cnt=1. D fires src 3 (d_last) → inflight_cnt=0, idle=1, no error.
- Duplicate: A src 5, then A src 5 again with no D → err_valid=1, err_code=1, err_source=5, inflight_cnt=1.
- Unknown D:
  - D src 9 with an empty bitmap → err_code=2, err_source=9.
  - Then D src 9 again → err_overflow=1.
  - Then err_clr → all capture fields 0.
- Same-cycle cases:
  - Src 2 in flight; D src 2 (last) and A src 2 in one cycle → no error, inflight_cnt stays 1.
  - Fresh src 4 with A and D in one cycle → D_UNKNOWN, inflight_cnt=1.
- Timeout with TIMEOUT=8:
  - A srcs 6 and 1, then stall → err_code=3, err_source=1 exactly 8 cycles after the first stalled cycle.
  - A D beat in the middle of the stall restarts the count.
  - Continued stall → err_overflow=1 after another 8 cycles.
  - Reset asserted mid-stall → all outputs return to reset values at once.
